// File: rtl/font_row_serializer.sv
// rtl/font_row_serializer.sv - serializes one glyph row from a built-in 8-bit font into a pixel stream
// Optional macro FONT_ROW_INVERT_EN adds the req_inv port for per-row pixel inversion.
module font_row_serializer #(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16,
  parameter int CODE_W  = 8,
  parameter int SCALE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] req_code,
  input  logic [3:0]        req_row,
  output logic              pix_valid,
  output logic              pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              miss
`ifdef FONT_ROW_INVERT_EN
  ,
  input  logic              req_inv
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam int NPIX = GLYPH_W * SCALE;

  logic [1:0]         state;
  logic [CODE_W-1:0]  code_q;
  logic [3:0]         row_q;
  logic               inv_q;
  logic [GLYPH_W-1:0] row_sh;
  logic [6:0]         pix_cnt;
  logic [1:0]         rep_cnt;
  logic               accept;
  logic [7:0]         glyph_bits;
  logic               glyph_miss;

  // Font lookup works from the captured request, so later input changes cannot disturb it.
  always_comb begin
    glyph_bits = 8'h00;
    glyph_miss = 1'b0;
    if ({1'b0, row_q} >= 5'(GLYPH_H)) begin
      glyph_miss = 1'b1;
    end else if (code_q == CODE_W'(8'h41)) begin
      case (row_q)
        4'd2:                          glyph_bits = 8'h08;
        4'd3:                          glyph_bits = 8'h14;
        4'd7:                          glyph_bits = 8'h3E;
        4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
        4'd10, 4'd11, 4'd12:           glyph_bits = 8'h22;
        default:                       glyph_bits = 8'h00;
      endcase
    end else if (code_q == CODE_W'(8'h42)) begin
      case (row_q)
        4'd2, 4'd12:                   glyph_bits = 8'h38;
        4'd3, 4'd11:                   glyph_bits = 8'h24;
        4'd6:                          glyph_bits = 8'h3C;
        4'd4, 4'd5, 4'd7, 4'd8,
        4'd9, 4'd10:                   glyph_bits = 8'h22;
        default:                       glyph_bits = 8'h00;
      endcase
    end else if (code_q != CODE_W'(8'h20)) begin
      glyph_miss = 1'b1;
    end
  end

  assign pix_valid = (state == SHIFT);
  assign pix_last  = pix_valid && (pix_cnt == 7'(NPIX - 1));
  assign req_ready = (state == IDLE) || pix_last;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign miss      = (state == FETCH) && glyph_miss;
  assign pix_data  = pix_valid && (row_sh[GLYPH_W-1] ^ inv_q);

`ifdef FONT_ROW_INVERT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= req_inv;
    end
  end
`else
  assign inv_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      code_q  <= '0;
      row_q   <= '0;
      row_sh  <= '0;
      pix_cnt <= '0;
      rep_cnt <= '0;
    end else begin
      if (accept) begin
        code_q <= req_code;
        row_q  <= req_row;
      end
      case (state)
        IDLE: begin
          if (accept) state <= FETCH;
        end
        FETCH: begin
          // Left-align the 8-bit glyph; extra right-hand columns stay zero.
          row_sh  <= GLYPH_W'(glyph_bits) << (GLYPH_W - 8);
          pix_cnt <= '0;
          rep_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (pix_last) begin
            state <= accept ? FETCH : IDLE;
          end else begin
            pix_cnt <= pix_cnt + 7'd1;
            if (rep_cnt == 2'(SCALE - 1)) begin
              rep_cnt <= '0;
              row_sh  <= row_sh << 1;
            end else begin
              rep_cnt <= rep_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_font_row_serializer.sv
// tb/tb_font_row_serializer.sv - directed self-checking bench for font_row_serializer
module tb_font_row_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready, pix_valid, pix_data, pix_last, busy, miss, req_inv;
  logic [7:0] req_code;
  logic [3:0] req_row;
  logic       b_req_valid, b_req_ready, b_pix_valid, b_pix_data, b_pix_last, b_busy, b_miss, b_req_inv;
  logic [7:0] b_req_code;
  logic [3:0] b_req_row;

  int checks = 0;
  int errors = 0;

  font_row_serializer u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .req_row(req_row), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .busy(busy), .miss(miss)
`ifdef FONT_ROW_INVERT_EN
    , .req_inv(req_inv)
`endif
  );

  font_row_serializer #(.GLYPH_W(10), .GLYPH_H(12), .CODE_W(8), .SCALE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_code(b_req_code), .req_row(b_req_row), .pix_valid(b_pix_valid), .pix_data(b_pix_data),
    .pix_last(b_pix_last), .busy(b_busy), .miss(b_miss)
`ifdef FONT_ROW_INVERT_EN
    , .req_inv(b_req_inv)
`endif
  );

  // Issue one request (sel=1 targets the wide/scaled instance); returns at the negedge of FETCH.
  task automatic start_row(input bit sel, input logic [7:0] code, input logic [3:0] row,
                           input logic inv, output logic fetch_miss, output logic fetch_pv);
    if (sel) begin
      b_req_valid = 1'b1; b_req_code = code; b_req_row = row; b_req_inv = inv;
    end else begin
      req_valid = 1'b1; req_code = code; req_row = row; req_inv = inv;
    end
    @(negedge clk);
    fetch_miss = sel ? b_miss : miss;
    fetch_pv   = sel ? b_pix_valid : pix_valid;
    if (sel) begin
      b_req_valid = 1'b0; b_req_code = 8'h42; b_req_row = row + 4'd1; b_req_inv = ~inv;
    end else begin
      req_valid = 1'b0; req_code = 8'h42; req_row = row + 4'd1; req_inv = ~inv;
    end
  endtask

  // Gather pixels until pix_last or a cycle budget runs out.
  task automatic collect(input bit sel, output logic [63:0] bits, output int n, output int misses,
                         output int first_wait, output logic last_ready);
    logic pv, pd, pl, ms, rd;
    bits = '0; n = 0; misses = 0; first_wait = -1; last_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      pv = sel ? b_pix_valid : pix_valid;
      pd = sel ? b_pix_data  : pix_data;
      pl = sel ? b_pix_last  : pix_last;
      ms = sel ? b_miss      : miss;
      rd = sel ? b_req_ready : req_ready;
      if (ms) misses++;
      if (pv) begin
        if (first_wait < 0) first_wait = i;
        bits = {bits[62:0], pd};
        n++;
        if (pl) begin
          last_ready = rd;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_code = '0; req_row = '0; req_inv = 1'b0;
    b_req_valid = 1'b0; b_req_code = '0; b_req_row = '0; b_req_inv = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, pix_valid, pix_data, pix_last, busy, miss} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 100000", {req_ready, pix_valid, pix_data, pix_last, busy, miss});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_a7();
    logic fm, fpv, lr;
    logic [63:0] bits;
    int n, ms, fw;
    start_row(0, 8'h41, 4'd7, 1'b0, fm, fpv);
    checks++;
    if (fpv !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL a7_fetch pv=%b busy=%b ready=%b want 0 1 0", fpv, busy, req_ready);
    end
    collect(0, bits, n, ms, fw, lr);
    checks++;
    if (n != 8 || bits[7:0] !== 8'b00111110) begin
      errors++; $display("FAIL a7_pixels got n=%0d %b want n=8 00111110", n, bits[7:0]);
    end
    checks++;
    if (fw != 0 || fm !== 1'b0 || ms != 0 || lr !== 1'b1) begin
      errors++; $display("FAIL a7_timing got wait=%0d miss=%b/%0d last_ready=%b want 0 0/0 1", fw, fm, ms, lr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL a7_idle got busy=%b ready=%b pv=%b want 0 1 0", busy, req_ready, pix_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b1, b2;
    int n1, n2, ms, fw;
    logic lr;
    req_valid = 1'b1; req_code = 8'h42; req_row = 4'd2; req_inv = 1'b0;
    @(negedge clk);
    req_code = 8'h41; req_row = 4'd3;
    collect(0, b1, n1, ms, fw, lr);
    checks++;
    if (n1 != 8 || b1[7:0] !== 8'b00111000) begin
      errors++; $display("FAIL b2_pixels got n=%0d %b want n=8 00111000", n1, b1[7:0]);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got pv=%b busy=%b want 0 1", pix_valid, busy);
    end
    req_valid = 1'b0; req_code = 8'h5A;
    collect(0, b2, n2, ms, fw, lr);
    checks++;
    if (n2 != 8 || b2[7:0] !== 8'b00010100 || fw != 0) begin
      errors++; $display("FAIL a3_pixels got n=%0d %b wait=%0d want n=8 00010100 0", n2, b2[7:0], fw);
    end
    @(negedge clk);
  endtask

  task automatic test_miss_and_space();
    logic fm, fpv, lr;
    logic [63:0] bits;
    int n, ms, fw;
    start_row(0, 8'h5A, 4'd4, 1'b0, fm, fpv);
    collect(0, bits, n, ms, fw, lr);
    checks++;
    if (fm !== 1'b1 || ms != 0) begin
      errors++; $display("FAIL miss_pulse got fetch=%b later=%0d want 1 0", fm, ms);
    end
    checks++;
    if (n != 8 || bits[7:0] !== 8'h00) begin
      errors++; $display("FAIL miss_pixels got n=%0d %b want n=8 00000000", n, bits[7:0]);
    end
    @(negedge clk);
    start_row(0, 8'h20, 4'd0, 1'b0, fm, fpv);
    collect(0, bits, n, ms, fw, lr);
    checks++;
    if (fm !== 1'b0 || n != 8 || bits[7:0] !== 8'h00) begin
      errors++; $display("FAIL space_row got miss=%b n=%0d %b want 0 8 00000000", fm, n, bits[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_scale_wide();
    logic fm, fpv, lr;
    logic [63:0] bits;
    int n, ms, fw;
    start_row(1, 8'h41, 4'd2, 1'b0, fm, fpv);
    collect(1, bits, n, ms, fw, lr);
    checks++;
    if (n != 20 || bits[19:0] !== 20'h00C00 || fm !== 1'b0) begin
      errors++; $display("FAIL scale_a2 got n=%0d %b miss=%b want n=20 00000000110000000000 0", n, bits[19:0], fm);
    end
    @(negedge clk);
    start_row(1, 8'h41, 4'd12, 1'b0, fm, fpv);
    collect(1, bits, n, ms, fw, lr);
    checks++;
    if (fm !== 1'b1 || n != 20 || bits[19:0] !== 20'h00000) begin
      errors++; $display("FAIL row_range got miss=%b n=%0d %b want 1 20 zeros", fm, n, bits[19:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_row();
    logic fm, fpv, lr;
    logic [63:0] bits;
    int n, ms, fw;
    start_row(0, 8'h41, 4'd7, 1'b0, fm, fpv);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, pix_valid, pix_data, pix_last, busy, miss} !== 6'b100000) begin
      errors++; $display("FAIL midrow_reset got %b want 100000", {req_ready, pix_valid, pix_data, pix_last, busy, miss});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL no_resume got pv=%b busy=%b want 0 0", pix_valid, busy);
    end
    start_row(0, 8'h41, 4'd7, 1'b0, fm, fpv);
    collect(0, bits, n, ms, fw, lr);
    checks++;
    if (n != 8 || bits[7:0] !== 8'b00111110) begin
      errors++; $display("FAIL post_reset_row got n=%0d %b want n=8 00111110", n, bits[7:0]);
    end
    @(negedge clk);
  endtask

`ifdef FONT_ROW_INVERT_EN
  task automatic test_invert();
    logic fm, fpv, lr;
    logic [63:0] bits;
    int n, ms, fw;
    start_row(0, 8'h20, 4'd0, 1'b1, fm, fpv);
    collect(0, bits, n, ms, fw, lr);
    checks++;
    if (fm !== 1'b0 || n != 8 || bits[7:0] !== 8'hFF) begin
      errors++; $display("FAIL invert_space got miss=%b n=%0d %b want 0 8 11111111", fm, n, bits[7:0]);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_a7();
    test_back_to_back();
    test_miss_and_space();
    test_scale_wide();
    test_reset_mid_row();
`ifdef FONT_ROW_INVERT_EN
    test_invert();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
